// File: rtl/run_ctrl_pkg.sv
// Shared types and reset values for the CPU run/step/halt sequencer.
// The optional breakpoint stop is compiled in with RUN_CTRL_BREAKPOINT_EN.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    HALT  = 2'd3
  } run_state_t;

  localparam run_state_t  STATE_RST     = PAUSE;
  localparam logic        CPU_CE_RST    = 1'b0;
  localparam logic [31:0] CYCLE_CNT_RST = 32'h0000_0000;
  localparam logic [31:0] CYCLE_CNT_MAX = 32'hFFFF_FFFF;
  localparam logic        BP_HIT_RST    = 1'b0;
  localparam logic        DEB_LEVEL_RST = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debouncer and
// a one-cycle pulse on each accepted 0->1 change of the stable level.
module btn_debounce
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_reg <= DEB_LEVEL_RST;
      cnt_reg    <= '0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      stable_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Rising edge of the stable level becomes a single-cycle press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_d_reg <= DEB_LEVEL_RST;
      press_reg    <= 1'b0;
    end else begin
      stable_d_reg <= stable_reg;
      press_reg    <= stable_reg & ~stable_d_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing a one-cycle CPU clock enable.
// Optional breakpoint stop in RUN is built when RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 3_125_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             step_btn,
  input  logic             halt,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] bp_addr,
  input  logic             bp_en,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [31:0]      cycle_cnt,
  output logic             bp_hit
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  run_state_t    state_reg;
  logic          cpu_ce_reg;
  logic [TW-1:0] tick_reg;
  logic [31:0]   cycle_cnt_reg;
  logic          step_press;
  logic          bp_stop;
  logic          bp_match;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (step_btn),
    .press (step_press)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_hit_reg;
  logic first_pulse_reg;

  // The first pulse after entering RUN skips the compare so a resume steps past the breakpoint.
  assign bp_match = bp_en && (pc == bp_addr) && !first_pulse_reg;
  assign bp_stop  = bp_hit_reg;
`else
  logic unused_bp;

  assign unused_bp = ^{pc, bp_addr, bp_en};
  assign bp_match  = 1'b0;
  assign bp_stop   = 1'b0;
`endif

  // Sequencer: state and cpu_ce are registered together so a pulse only appears in RUN or STEP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= STATE_RST;
      cpu_ce_reg <= CPU_CE_RST;
      tick_reg   <= '0;
`ifdef RUN_CTRL_BREAKPOINT_EN
      bp_hit_reg      <= BP_HIT_RST;
      first_pulse_reg <= 1'b1;
`endif
    end else begin
      cpu_ce_reg <= 1'b0;
      if (halt) begin
        state_reg <= HALT;
      end else begin
        unique case (state_reg)
          PAUSE: begin
            if (run_en && !bp_stop) begin
              state_reg <= RUN;
              tick_reg  <= '0;
`ifdef RUN_CTRL_BREAKPOINT_EN
              first_pulse_reg <= 1'b1;
`endif
            end else if (step_press) begin
              state_reg  <= STEP;
              cpu_ce_reg <= 1'b1;
`ifdef RUN_CTRL_BREAKPOINT_EN
              bp_hit_reg <= 1'b0;
`endif
            end
          end
          RUN: begin
            if (!run_en) begin
              state_reg <= PAUSE;
            end else if (tick_reg == TICK_LAST) begin
              tick_reg <= '0;
              if (bp_match) begin
                state_reg <= PAUSE;
`ifdef RUN_CTRL_BREAKPOINT_EN
                bp_hit_reg <= 1'b1;
`endif
              end else begin
                cpu_ce_reg <= 1'b1;
`ifdef RUN_CTRL_BREAKPOINT_EN
                first_pulse_reg <= 1'b0;
`endif
              end
            end else begin
              tick_reg <= tick_reg + TW'(1);
            end
          end
          STEP: state_reg <= PAUSE;
          HALT: state_reg <= HALT;
        endcase
      end
`ifdef RUN_CTRL_BREAKPOINT_EN
      // Dropping the run switch always acknowledges a breakpoint stop.
      if (!run_en) begin
        bp_hit_reg <= 1'b0;
      end
`endif
    end
  end

  // Count issued enables, saturating at the top of the range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_reg <= CYCLE_CNT_RST;
    end else if (cpu_ce_reg && (cycle_cnt_reg != CYCLE_CNT_MAX)) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign cpu_ce    = cpu_ce_reg;
  assign state     = state_reg;
  assign cycle_cnt = cycle_cnt_reg;
  assign bp_hit    = bp_stop;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt sequencer for the pipelined CPU on the FPGA board. Replaces the free-running divided CPU clock with a single board clock plus a one-cycle `cpu_ce` enable. Supports continuous run at a fixed divided rate, single-step from a debounced push button, and a sticky stop when the CPU reports `halt`. Exposes state and an executed-cycle count for the hex display and LEDs.

## Interface
- `TICK_DIV`, 3_125_000, board cycles between `cpu_ce` pulses in RUN; must be ≥ 2.
- `DEB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a button level change; must be ≥ 1.
- `WIDTH`, 32, width of `pc` / `bp_addr`.
- `clk` in 1: board clock, the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `run_en` in 1: level run request (slide switch), synchronous to `clk`.
- `step_btn` in 1: raw asynchronous, bouncy step push button.
- `halt` in 1: CPU halt flag, synchronous to `clk`.
- `pc` in WIDTH: current CPU PC (breakpoint compare only).
- `bp_addr` in WIDTH: breakpoint address.
- `bp_en` in 1: breakpoint enable.
- `cpu_ce` out 1: CPU clock enable, one-cycle pulses.
- `state` out 2: current state encoding.
- `cycle_cnt` out 32: number of `cpu_ce` pulses issued.
- `bp_hit` out 1: breakpoint stop flag.

## Operation
- States: PAUSE=0, RUN=1, STEP=2, HALT=3.
- Reset (rst_n=0 at a clk edge) puts: state=PAUSE, cpu_ce=0, cycle_cnt=0, bp_hit=0, tick counter=0, debouncer stable level=0, debounce counter=0.
- PAUSE: if run_en=1 and bp_hit=0, go to RUN and clear the tick counter. Else, on a step press pulse, go to STEP.
- RUN: tick counter counts 0..TICK_DIV-1 and wraps. When the counter is at TICK_DIV-1, assert cpu_ce for one cycle. If run_en=0, go to PAUSE; no pulse is issued in that cycle.
- STEP: lasts exactly one cycle, with cpu_ce=1, then returns to PAUSE.
- HALT: cpu_ce=0. Sticky; left only via reset.
- Step presses are ignored in RUN, STEP and HALT.
- Priority each cycle: halt=1 (go to HALT, no pulse) > run_en=0 > breakpoint > tick pulse.
- cpu_ce and state are registered together, so cpu_ce=1 only while state is RUN or STEP.
- cycle_cnt increments on every cycle with cpu_ce=1 and saturates at 32'hFFFF_FFFF.
- Debounce:
  - 2-FF synchronizer on step_btn.
  - The counter runs while the synchronized level differs from the stable level and resets when they match.
  - After DEB_CYCLES consecutive differing cycles, the stable level is updated.
  - A 0→1 transition of the stable level produces a one-cycle press pulse.

## Timing
- Clean press to press pulse: 2 sync cycles + DEB_CYCLES + 1 cycle.
- Press pulse (state PAUSE) to STEP with cpu_ce=1: next cycle. Back to PAUSE the cycle after.
- PAUSE→RUN: first cpu_ce occurs TICK_DIV cycles after entering RUN. Pulses then repeat every TICK_DIV cycles.
- halt to HALT: one cycle. A halt coinciding with a STEP cycle still moves to HALT next; the STEP pulse already issued counts.
- Tick counter width: $clog2(TICK_DIV).

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined:
  - Applies in RUN at the tick terminal cycle, when bp_en=1 and pc==bp_addr.
  - On a match: suppress the pulse, go to PAUSE, set bp_hit=1.
  - The compare is skipped for the first pulse after each RUN entry, so resuming moves past the breakpoint.
  - bp_hit clears when run_en=0 or on a step press in PAUSE.
- Undefined: pc, bp_addr and bp_en are ignored; bp_hit is tied to 0; no compare logic is built.

## Structure
- Package `run_ctrl_pkg` holds:
  - `run_state_t`, 2-bit enum PAUSE/RUN/STEP/HALT with the encodings above.
  - The reset-value constants.
- Sub-module `btn_debounce` (params DEB_CYCLES; ports clk, rst_n, raw, press) holds the synchronizer, stable level and press pulse.

## Test plan
All scenarios use TICK_DIV=4, DEB_CYCLES=3.
- Reset, run_en=1 for 20 cycles → cpu_ce pulses at RUN-entry+4, +8, +12, +16; cycle_cnt=4; state=1.
- run_en=1 then 0 on a terminal-count cycle → no pulse that cycle; state=0 next cycle.
- Step: bounce step_btn 1/0/1 over 3 cycles, then hold high for 10 → exactly one STEP cycle with cpu_ce=1; cycle_cnt=1; state back to 0.
- halt=1 during RUN → state=3 next cycle, no further cpu_ce. Toggling run_en and step is ignored. rst_n=0 → state=0, cycle_cnt=0.
- Breakpoint (macro on):
  - bp_en=1, bp_addr=pc=0x10 before the second pulse → first pulse issued, second suppressed; state=0; bp_hit=1.
  - run_en 0→1 → bp_hit=0; RUN resumes and the next pulse is issued.
- Macro off, same stimulus as the breakpoint scenario → bp_hit stays 0 and pulses continue.
